// File: rtl/mips31_pkg.sv
// mips31_pkg
// Shared definitions for the 31-instruction MIPS subset:
//   - opcode / funct field encodings
//   - one-hot bit positions of the decoded instruct vector (controller uses these too)
//   - fetch/decode FSM state type
package mips31_pkg;

  // Primary opcode field [31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Function field [5:0] for R-type words
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // One-hot positions in instruct; bit 31 is reserved and never set
  localparam int ADD_I   = 0;
  localparam int ADDU_I  = 1;
  localparam int SUB_I   = 2;
  localparam int SUBU_I  = 3;
  localparam int AND_I   = 4;
  localparam int OR_I    = 5;
  localparam int XOR_I   = 6;
  localparam int NOR_I   = 7;
  localparam int SLT_I   = 8;
  localparam int SLTU_I  = 9;
  localparam int SLL_I   = 10;
  localparam int SRL_I   = 11;
  localparam int SRA_I   = 12;
  localparam int SLLV_I  = 13;
  localparam int SRLV_I  = 14;
  localparam int SRAV_I  = 15;
  localparam int JR_I    = 16;
  localparam int ADDI_I  = 17;
  localparam int ADDIU_I = 18;
  localparam int ANDI_I  = 19;
  localparam int ORI_I   = 20;
  localparam int XORI_I  = 21;
  localparam int LW_I    = 22;
  localparam int SW_I    = 23;
  localparam int BEQ_I   = 24;
  localparam int BNE_I   = 25;
  localparam int SLTI_I  = 26;
  localparam int SLTIU_I = 27;
  localparam int LUI_I   = 28;
  localparam int J_I     = 29;
  localparam int JAL_I   = 30;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_EXEC    = 2'd2,
    ST_BACKOFF = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/mips31_decode.sv
// mips31_decode
// Purely combinational decoder: instruction word -> one-hot instruct vector.
// Ports:
//   i_word   [31:0] instruction word
//   o_onehot [31:0] one-hot decode, all zero for an unsupported word
module mips31_decode
  import mips31_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_onehot
);

  logic [5:0] w_op;
  logic [5:0] w_funct;
  logic       w_unused;

  assign w_op     = i_word[31:26];
  assign w_funct  = i_word[5:0];
  // Register/immediate fields are irrelevant to the decode
  assign w_unused = ^i_word[25:6];

  // R-type words select on funct, everything else selects on op;
  // anything unmatched leaves the vector all zero.
  always_comb begin
    o_onehot = '0;
    case (w_op)
      OP_RTYPE: begin
        case (w_funct)
          FN_ADD:  o_onehot[ADD_I]  = 1'b1;
          FN_ADDU: o_onehot[ADDU_I] = 1'b1;
          FN_SUB:  o_onehot[SUB_I]  = 1'b1;
          FN_SUBU: o_onehot[SUBU_I] = 1'b1;
          FN_AND:  o_onehot[AND_I]  = 1'b1;
          FN_OR:   o_onehot[OR_I]   = 1'b1;
          FN_XOR:  o_onehot[XOR_I]  = 1'b1;
          FN_NOR:  o_onehot[NOR_I]  = 1'b1;
          FN_SLT:  o_onehot[SLT_I]  = 1'b1;
          FN_SLTU: o_onehot[SLTU_I] = 1'b1;
          FN_SLL:  o_onehot[SLL_I]  = 1'b1;
          FN_SRL:  o_onehot[SRL_I]  = 1'b1;
          FN_SRA:  o_onehot[SRA_I]  = 1'b1;
          FN_SLLV: o_onehot[SLLV_I] = 1'b1;
          FN_SRLV: o_onehot[SRLV_I] = 1'b1;
          FN_SRAV: o_onehot[SRAV_I] = 1'b1;
          FN_JR:   o_onehot[JR_I]   = 1'b1;
          default: o_onehot = '0;
        endcase
      end
      OP_ADDI:  o_onehot[ADDI_I]  = 1'b1;
      OP_ADDIU: o_onehot[ADDIU_I] = 1'b1;
      OP_ANDI:  o_onehot[ANDI_I]  = 1'b1;
      OP_ORI:   o_onehot[ORI_I]   = 1'b1;
      OP_XORI:  o_onehot[XORI_I]  = 1'b1;
      OP_LW:    o_onehot[LW_I]    = 1'b1;
      OP_SW:    o_onehot[SW_I]    = 1'b1;
      OP_BEQ:   o_onehot[BEQ_I]   = 1'b1;
      OP_BNE:   o_onehot[BNE_I]   = 1'b1;
      OP_SLTI:  o_onehot[SLTI_I]  = 1'b1;
      OP_SLTIU: o_onehot[SLTIU_I] = 1'b1;
      OP_LUI:   o_onehot[LUI_I]   = 1'b1;
      OP_J:     o_onehot[J_I]     = 1'b1;
      OP_JAL:   o_onehot[JAL_I]   = 1'b1;
      default:  o_onehot = '0;
    endcase
  end

endmodule

// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode
// Fetch/decode stage ahead of the single-cycle controller. Owns the PC, fetches
// one word at a time over a req/ack handshake with timeout + retry, latches and
// decodes the word, then gives the datapath a one-cycle exec_en commit strobe.
// Ports:
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   o_imem_req/o_imem_addr fetch request and address (address = pc)
//   i_imem_ack/i_imem_rdata memory response
//   i_next_pc             PC of the following instruction, taken at end of exec
//   o_pc, o_instr         current PC and raw latched instruction word
//   o_instruct            one-hot decode of o_instr
//   o_exec_en, o_illegal  commit strobe, and illegal-word flag alongside it
//   o_fetch_err           one-cycle pulse when a fetch times out
module instr_fetch_decode
  import mips31_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  input  logic [31:0] i_next_pc,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr,
  output logic [31:0] o_instruct,
  output logic        o_exec_en,
  output logic        o_illegal,
  output logic        o_fetch_err
);

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic [31:0]  r_instruct;
  logic [7:0]   r_count;
  logic         r_imem_req;
  logic         r_exec_en;
  logic [31:0]  w_onehot;
  logic         w_expire;

  mips31_decode u_decode (
    .i_word   (i_imem_rdata),
    .o_onehot (w_onehot)
  );

  // The timeout fires only if no ack shows up in the final wait cycle, so
  // this has to look at the live ack rather than be precomputed a cycle early.
  assign w_expire = (r_state == ST_REQ) && !i_imem_ack && (r_count == LAST_COUNT);

  // Fetch FSM. req/exec_en are registered alongside the state transitions so
  // they line up exactly with REQ and EXEC.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_instruct <= '0;
      r_count    <= '0;
      r_imem_req <= 1'b0;
      r_exec_en  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_count    <= '0;
          r_imem_req <= 1'b1;
          r_state    <= ST_REQ;
        end
        ST_REQ: begin
          if (i_imem_ack) begin
            r_instr    <= i_imem_rdata;
            r_instruct <= w_onehot;
            r_count    <= '0;
            r_imem_req <= 1'b0;
            r_exec_en  <= 1'b1;
            r_state    <= ST_EXEC;
          end else if (r_count == LAST_COUNT) begin
            r_count    <= '0;
            r_imem_req <= 1'b0;
            r_state    <= ST_BACKOFF;
          end else begin
            r_count <= r_count + 8'd1;
          end
        end
        ST_EXEC: begin
          // Illegal words advance too; the controller simply sees no bit set.
          r_pc       <= i_next_pc;
          r_count    <= '0;
          r_exec_en  <= 1'b0;
          r_imem_req <= 1'b1;
          r_state    <= ST_REQ;
        end
        ST_BACKOFF: begin
          r_count    <= '0;
          r_imem_req <= 1'b1;
          r_state    <= ST_REQ;
        end
        default: begin
          r_count    <= '0;
          r_imem_req <= 1'b0;
          r_exec_en  <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_imem_req  = r_imem_req;
  assign o_imem_addr = r_pc;
  assign o_pc        = r_pc;
  assign o_instr     = r_instr;
  assign o_instruct  = r_instruct;
  assign o_exec_en   = r_exec_en;
  assign o_illegal   = r_exec_en && (r_instruct == 32'd0);
  assign o_fetch_err = w_expire;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// tb_instr_fetch_decode
// Directed-vector bench for instr_fetch_decode (built with TIMEOUT=4).
module tb_instr_fetch_decode;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clk;
  logic        rstN;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemRdata;
  logic [31:0] nextPc;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] instruct;
  logic        execEn;
  logic        illegal;
  logic        fetchErr;

  int vecCount;
  int errCount;
  logic [31:0] expPc;

  instr_fetch_decode #(
    .RESET_PC (RESET_PC),
    .TIMEOUT  (4)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .o_imem_req   (imemReq),
    .o_imem_addr  (imemAddr),
    .i_imem_ack   (imemAck),
    .i_imem_rdata (imemRdata),
    .i_next_pc    (nextPc),
    .o_pc         (pc),
    .o_instr      (instr),
    .o_instruct   (instruct),
    .o_exec_en    (execEn),
    .o_illegal    (illegal),
    .o_fetch_err  (fetchErr)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle a little past it
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Hold reset for two edges, release, then step into the first REQ cycle
  task automatic doReset();
    rstN    = 1'b0;
    imemAck = 1'b0;
    tick();
    tick();
    rstN = 1'b1;
    tick();
    expPc = RESET_PC;
  endtask

  task automatic test_reset();
    rstN      = 1'b0;
    imemAck   = 1'b0;
    imemRdata = 32'h0;
    nextPc    = 32'h0;
    tick();
    tick();
    vecCount++;
    if (imemReq !== 1'b0) begin errCount++; $display("[TB] FAIL reset_req got %0b want 0", imemReq); end
    vecCount++;
    if (pc !== RESET_PC) begin errCount++; $display("[TB] FAIL reset_pc got %h want %h", pc, RESET_PC); end
    vecCount++;
    if (instr !== 32'h0) begin errCount++; $display("[TB] FAIL reset_instr got %h want 0", instr); end
    vecCount++;
    if (instruct !== 32'h0) begin errCount++; $display("[TB] FAIL reset_instruct got %h want 0", instruct); end
    vecCount++;
    if ({execEn, illegal, fetchErr} !== 3'b000) begin errCount++; $display("[TB] FAIL reset_strobes got %b want 000", {execEn, illegal, fetchErr}); end
    rstN = 1'b1;
    tick();
    expPc = RESET_PC;
  endtask

  // addu fetched with a few wait cycles
  task automatic test_wait_ack();
    vecCount++;
    if (imemReq !== 1'b1) begin errCount++; $display("[TB] FAIL first_req got %0b want 1", imemReq); end
    vecCount++;
    if (imemAddr !== RESET_PC) begin errCount++; $display("[TB] FAIL first_addr got %h want %h", imemAddr, RESET_PC); end
    tick();
    vecCount++;
    if (execEn !== 1'b0) begin errCount++; $display("[TB] FAIL wait_exec got %0b want 0", execEn); end
    tick();
    imemAck   = 1'b1;
    imemRdata = 32'h0022_1821;
    nextPc    = expPc + 32'd4;
    #1;
    vecCount++;
    if (fetchErr !== 1'b0) begin errCount++; $display("[TB] FAIL wait_ferr got %0b want 0", fetchErr); end
    tick();
    imemAck = 1'b0;
    vecCount++;
    if (execEn !== 1'b1) begin errCount++; $display("[TB] FAIL addu_exec got %0b want 1", execEn); end
    vecCount++;
    if (instruct !== 32'h0000_0002) begin errCount++; $display("[TB] FAIL addu_instruct got %h want 00000002", instruct); end
    vecCount++;
    if (illegal !== 1'b0) begin errCount++; $display("[TB] FAIL addu_illegal got %0b want 0", illegal); end
    vecCount++;
    if (instr !== 32'h0022_1821) begin errCount++; $display("[TB] FAIL addu_instr got %h want 00221821", instr); end
    vecCount++;
    if (imemReq !== 1'b0) begin errCount++; $display("[TB] FAIL addu_req_in_exec got %0b want 0", imemReq); end
    tick();
    expPc = expPc + 32'd4;
    vecCount++;
    if (execEn !== 1'b0) begin errCount++; $display("[TB] FAIL addu_exec_one_cycle got %0b want 0", execEn); end
    vecCount++;
    if (pc !== expPc) begin errCount++; $display("[TB] FAIL addu_next_pc got %h want %h", pc, expPc); end
  endtask

  // lw, sw, beq, jal with zero-wait memory: one exec every second cycle
  task automatic test_back_to_back();
    logic [31:0] words [4];
    int          bits  [4];
    words[0] = 32'h8C22_0004; bits[0] = 22;
    words[1] = 32'hAC22_0004; bits[1] = 23;
    words[2] = 32'h1022_0003; bits[2] = 24;
    words[3] = 32'h0C10_0000; bits[3] = 30;
    doReset();
    for (int i = 0; i < 4; i++) begin
      vecCount++;
      if (imemReq !== 1'b1 || imemAddr !== RESET_PC + 32'(4 * i)) begin
        errCount++;
        $display("[TB] FAIL b2b_req[%0d] got req=%0b addr=%h want req=1 addr=%h", i, imemReq, imemAddr, RESET_PC + 32'(4 * i));
      end
      imemAck   = 1'b1;
      imemRdata = words[i];
      nextPc    = RESET_PC + 32'(4 * i + 4);
      tick();
      imemAck = 1'b0;
      vecCount++;
      if (execEn !== 1'b1 || instruct !== (32'h1 << bits[i])) begin
        errCount++;
        $display("[TB] FAIL b2b_decode[%0d] got exec=%0b instruct=%h want exec=1 instruct=%h", i, execEn, instruct, 32'h1 << bits[i]);
      end
      vecCount++;
      if (pc !== RESET_PC + 32'(4 * i)) begin
        errCount++;
        $display("[TB] FAIL b2b_pc[%0d] got %h want %h", i, pc, RESET_PC + 32'(4 * i));
      end
      tick();
    end
    expPc = RESET_PC + 32'd16;
  endtask

  // Unknown opcode: illegal with exec_en, PC still follows next_pc
  task automatic test_illegal();
    imemAck   = 1'b1;
    imemRdata = 32'hFC00_0000;
    nextPc    = 32'h0040_0100;
    tick();
    imemAck = 1'b0;
    vecCount++;
    if ({execEn, illegal} !== 2'b11) begin errCount++; $display("[TB] FAIL illegal_flags got %b want 11", {execEn, illegal}); end
    vecCount++;
    if (instruct !== 32'h0) begin errCount++; $display("[TB] FAIL illegal_instruct got %h want 0", instruct); end
    tick();
    expPc = 32'h0040_0100;
    vecCount++;
    if (imemReq !== 1'b1 || imemAddr !== expPc) begin errCount++; $display("[TB] FAIL illegal_next_addr got req=%0b addr=%h want req=1 addr=%h", imemReq, imemAddr, expPc); end
  endtask

  // No ack for 4 cycles, backoff, retry; then ack exactly on the expiry cycle
  task automatic test_timeout();
    imemAck = 1'b0;
    #1;
    vecCount++;
    if (fetchErr !== 1'b0) begin errCount++; $display("[TB] FAIL to_early_ferr got %0b want 0", fetchErr); end
    tick();
    tick();
    vecCount++;
    if (fetchErr !== 1'b0) begin errCount++; $display("[TB] FAIL to_third_ferr got %0b want 0", fetchErr); end
    tick();
    vecCount++;
    if (fetchErr !== 1'b1 || imemReq !== 1'b1) begin errCount++; $display("[TB] FAIL to_expire got ferr=%0b req=%0b want 1/1", fetchErr, imemReq); end
    tick();
    vecCount++;
    if (imemReq !== 1'b0 || fetchErr !== 1'b0) begin errCount++; $display("[TB] FAIL to_backoff got req=%0b ferr=%0b want 0/0", imemReq, fetchErr); end
    tick();
    vecCount++;
    if (imemReq !== 1'b1 || imemAddr !== expPc) begin errCount++; $display("[TB] FAIL to_retry got req=%0b addr=%h want req=1 addr=%h", imemReq, imemAddr, expPc); end
    tick();
    tick();
    tick();
    imemAck   = 1'b1;
    imemRdata = 32'h2001_0005;
    nextPc    = expPc + 32'd4;
    #1;
    vecCount++;
    if (fetchErr !== 1'b0) begin errCount++; $display("[TB] FAIL to_ack_wins_ferr got %0b want 0", fetchErr); end
    tick();
    imemAck = 1'b0;
    vecCount++;
    if (execEn !== 1'b1 || instruct !== (32'h1 << 17)) begin errCount++; $display("[TB] FAIL to_ack_wins_exec got exec=%0b instruct=%h want exec=1 instruct=%h", execEn, instruct, 32'h1 << 17); end
    tick();
    expPc = expPc + 32'd4;
  endtask

  // Reset while a fetch at 0x00400040 is pending, with ack in the reset cycle
  task automatic test_reset_midfetch();
    imemAck   = 1'b1;
    imemRdata = 32'h0000_0000;
    nextPc    = 32'h0040_0040;
    tick();
    imemAck = 1'b0;
    tick();
    vecCount++;
    if (imemReq !== 1'b1 || imemAddr !== 32'h0040_0040) begin errCount++; $display("[TB] FAIL mid_setup got req=%0b addr=%h want req=1 addr=00400040", imemReq, imemAddr); end
    rstN      = 1'b0;
    imemAck   = 1'b1;
    imemRdata = 32'h0022_1821;
    tick();
    vecCount++;
    if (execEn !== 1'b0) begin errCount++; $display("[TB] FAIL mid_exec got %0b want 0", execEn); end
    vecCount++;
    if (pc !== RESET_PC || instr !== 32'h0 || instruct !== 32'h0) begin errCount++; $display("[TB] FAIL mid_state got pc=%h instr=%h instruct=%h want pc=%h instr=0 instruct=0", pc, instr, instruct, RESET_PC); end
    rstN = 1'b1;
    tick();
    imemAck = 1'b0;
    vecCount++;
    if (execEn !== 1'b0 || imemReq !== 1'b1 || imemAddr !== RESET_PC) begin errCount++; $display("[TB] FAIL mid_resume got exec=%0b req=%0b addr=%h want 0/1/%h", execEn, imemReq, imemAddr, RESET_PC); end
    tick();
    vecCount++;
    if (execEn !== 1'b0) begin errCount++; $display("[TB] FAIL mid_late_ack got %0b want 0", execEn); end
    expPc = RESET_PC;
  endtask

  // Every supported funct plus one unsupported funct (001001)
  task automatic test_rtype_sweep();
    logic [5:0] functs [18];
    int         bits   [18];
    functs[0]  = 6'h20; bits[0]  = 0;
    functs[1]  = 6'h21; bits[1]  = 1;
    functs[2]  = 6'h22; bits[2]  = 2;
    functs[3]  = 6'h23; bits[3]  = 3;
    functs[4]  = 6'h24; bits[4]  = 4;
    functs[5]  = 6'h25; bits[5]  = 5;
    functs[6]  = 6'h26; bits[6]  = 6;
    functs[7]  = 6'h27; bits[7]  = 7;
    functs[8]  = 6'h2A; bits[8]  = 8;
    functs[9]  = 6'h2B; bits[9]  = 9;
    functs[10] = 6'h00; bits[10] = 10;
    functs[11] = 6'h02; bits[11] = 11;
    functs[12] = 6'h03; bits[12] = 12;
    functs[13] = 6'h04; bits[13] = 13;
    functs[14] = 6'h06; bits[14] = 14;
    functs[15] = 6'h07; bits[15] = 15;
    functs[16] = 6'h08; bits[16] = 16;
    functs[17] = 6'h09; bits[17] = -1;
    for (int i = 0; i < 18; i++) begin
      logic [31:0] expInstruct;
      expInstruct = (bits[i] < 0) ? 32'h0 : (32'h1 << bits[i]);
      imemAck   = 1'b1;
      imemRdata = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, functs[i]};
      nextPc    = expPc + 32'd4;
      tick();
      imemAck = 1'b0;
      vecCount++;
      if (execEn !== 1'b1 || instruct !== expInstruct || illegal !== (bits[i] < 0)) begin
        errCount++;
        $display("[TB] FAIL sweep_funct_%h got exec=%0b instruct=%h illegal=%0b want exec=1 instruct=%h illegal=%0b",
                 functs[i], execEn, instruct, illegal, expInstruct, (bits[i] < 0));
      end
      tick();
      expPc = expPc + 32'd4;
      vecCount++;
      if (imemAddr !== expPc) begin errCount++; $display("[TB] FAIL sweep_addr[%0d] got %h want %h", i, imemAddr, expPc); end
    end
  endtask

  initial begin
    vecCount  = 0;
    errCount  = 0;
    rstN      = 1'b0;
    imemAck   = 1'b0;
    imemRdata = 32'h0;
    nextPc    = 32'h0;
    expPc     = RESET_PC;
    test_reset();
    test_wait_ack();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_reset_midfetch();
    test_rtype_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
